dmem_arbiter: RTL and testbench

Sequencing controller and arbiter for the single-port data memory in the MM stage. It shares the memory between the pipeline (ex_mm MemRead/MemWrite traffic) and a DMA/loader requester. It enforces a fixed multi-cycle memory latency and raises a pipeline stall while the pipeline's access is pending. It sits between the ex_mm register outputs, the mm_wb input and the Data_mem instance.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_lat_timer.sv | 26 ++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the MM-stage data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, P_ACC, P_DONE, D_ACC} arb_state_e;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Latency counter width; a one-cycle memory still needs a 1-bit register.
  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/dmem_lat_timer.sv
// Fixed-latency access counter: runs 0..MEM_LAT-1 while an access is active.
module dmem_lat_timer
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic last
);

  localparam int CW = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  assign last = run && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (last) cnt <= '0;
    else if (run)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory sequencer shared by the pipeline MM stage and a DMA/loader.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int DW         = 32,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_e    state;
  logic [SW-1:0] starve;
  logic          run, last;
  logic          d_live, p_win, d_win;

  assign run = (state == P_ACC) || (state == D_ACC);

  dmem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .last  (last)
  );

  // The requester still holds d_req while d_done is up; that is the finished access, not a new one.
  assign d_live  = d_req && !d_done;
  assign p_win   = p_req && !(d_live && (starve == SMAX));
  assign d_win   = d_live && !p_win;
  assign p_stall = reset && p_req && (state != P_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      starve  <= '0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      p_rdata <= '0;
      d_rdata <= '0;
      d_gnt   <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      d_gnt  <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!d_req) starve <= '0;
          if (p_win) begin
            state   <= P_ACC;
            m_en    <= 1'b1;
            m_we    <= p_we;
            m_addr  <= p_addr;
            m_wdata <= p_wdata;
            if (d_req && starve != SMAX) starve <= starve + SW'(1);
          end else if (d_win) begin
            state   <= D_ACC;
            m_en    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            d_gnt   <= 1'b1;
            starve  <= '0;
          end
        end
        P_ACC: if (last) begin
          m_en  <= 1'b0;
          state <= P_DONE;
          if (!m_we) p_rdata <= m_rdata;
        end
        D_ACC: if (last) begin
          m_en   <= 1'b0;
          state  <= IDLE;
          d_done <= 1'b1;
          if (!m_we) d_rdata <= m_rdata;
        end
        P_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter against a timeline-level reference model.
module tb_dmem_arbiter;

  localparam int L  = 2;
  localparam int SM = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        p_req = 0, p_we = 0, d_req = 0, d_we = 0;
  logic [31:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] p_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        p_stall, d_gnt, d_done, m_en, m_we;

  dmem_arbiter #(.MEM_LAT(L), .STARVE_MAX(SM), .DW(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory: a write lands only after L consecutive enabled cycles.
  logic [31:0] mem [256];
  logic        mem_clr = 1'b1;
  int          wrun;

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : {8'(i), 8'(~i), 8'(i * 3), 8'h5A};
  endfunction

  assign m_rdata = mem[m_addr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      wrun <= 0;
    end else if (m_en && m_we) begin
      if (wrun == L - 1) begin
        mem[m_addr[7:0]] <= m_wdata;
        wrun <= 0;
      end else wrun <= wrun + 1;
    end else wrun <= 0;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: accesses as time windows on a cycle line.
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;

  int          cyc = 0, free_at = 0, acc_start = -9, acc_end = -9, owner = 0;
  int          starve = 0, pdone_cyc = -9, ddone_cyc = -9;
  logic        a_we;
  logic [31:0] a_addr, a_wdata, exp_pr = 0, exp_dr = 0;
  logic [31:0] mm [256];

  bit   p_pend = 0, d_pend = 0, d_granted = 0, rand_en = 0, log_en = 0, prev_men = 0;
  int   p_prob = 0, d_prob = 0, wd_prob = 0, n_log = 0;
  logic [31:0] order = 0;
  req_t pq[$], dq[$];

  function automatic req_t rnd_req();
    req_t r;
    r.we = 1'($urandom_range(1));
    r.addr = 32'($urandom_range(255));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive();
    req_t r;
    if (!p_pend) begin
      if (pq.size() > 0) begin r = pq.pop_front(); p_pend = 1; end
      else if (rand_en && $urandom_range(99) < p_prob) begin r = rnd_req(); p_pend = 1; end
      if (p_pend) begin p_we = r.we; p_addr = r.addr; p_wdata = r.wdata; end
    end
    p_req = p_pend;
    if (d_pend && !d_granted && rand_en && $urandom_range(99) < wd_prob) d_pend = 0;
    if (!d_pend) begin
      if (dq.size() > 0) begin r = dq.pop_front(); d_pend = 1; end
      else if (rand_en && $urandom_range(99) < d_prob) begin r = rnd_req(); d_pend = 1; end
      if (d_pend) begin d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; end
    end
    d_req = d_pend;
  endtask

  task automatic cycle_chk();
    bit in_acc, dl;
    @(negedge clk);
    in_acc = owner != 0 && cyc >= acc_start && cyc <= acc_end;
    chk("m_en", 32'(m_en), 32'(in_acc));
    if (in_acc) begin
      chk("m_we", 32'(m_we), 32'(a_we));
      chk("m_addr", m_addr, a_addr);
      chk("m_wdata", m_wdata, a_wdata);
    end
    chk("p_stall", 32'(p_stall), 32'(p_req && cyc != pdone_cyc));
    chk("d_gnt", 32'(d_gnt), 32'(owner == 2 && cyc == acc_start));
    chk("d_done", 32'(d_done), 32'(cyc == ddone_cyc));
    chk("p_rdata", p_rdata, exp_pr);
    chk("d_rdata", d_rdata, exp_dr);
    if (log_en && m_en && !prev_men) begin order = {order[30:0], d_gnt}; n_log++; end
    prev_men = m_en;
    if (in_acc && cyc == acc_end) begin
      if (a_we)            mm[a_addr[7:0]] = a_wdata;
      else if (owner == 1) exp_pr = mm[a_addr[7:0]];
      else                 exp_dr = mm[a_addr[7:0]];
    end
    if (cyc >= free_at) begin
      dl = d_req && cyc != ddone_cyc;
      if (!d_req) starve = 0;
      if (p_req && !(dl && starve == SM)) begin
        owner = 1; a_we = p_we; a_addr = p_addr; a_wdata = p_wdata;
        if (d_req) starve = (starve < SM) ? starve + 1 : SM;
        acc_start = cyc + 1; acc_end = cyc + L;
        pdone_cyc = cyc + L + 1; free_at = cyc + L + 2;
      end else if (dl) begin
        owner = 2; a_we = d_we; a_addr = d_addr; a_wdata = d_wdata;
        starve = 0; d_granted = 1;
        acc_start = cyc + 1; acc_end = cyc + L;
        ddone_cyc = cyc + L + 1; free_at = cyc + L + 1;
      end
    end
    if (cyc == pdone_cyc) p_pend = 0;
    if (cyc == ddone_cyc) begin d_pend = 0; d_granted = 0; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 0; p_req = 1; d_req = 0;
    p_pend = 0; d_pend = 0; d_granted = 0; pq.delete(); dq.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_m_en", 32'(m_en), 0);
      chk("rst_m_we", 32'(m_we), 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_p_stall", 32'(p_stall), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_d_done", 32'(d_done), 0);
      chk("rst_p_rdata", p_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      @(posedge clk); #1;
      cyc++;
    end
    p_req = 0; reset = 1;
    owner = 0; starve = 0; exp_pr = 0; exp_dr = 0; free_at = cyc;
    acc_start = -9; acc_end = -9; pdone_cyc = -9; ddone_cyc = -9; prev_men = 0;
  endtask

  task automatic settle(input int extra);
    int k = 0;
    rand_en = 0;
    while ((p_pend || d_pend || pq.size() > 0 || dq.size() > 0 || cyc < free_at) && k < 300) begin
      drive(); cycle_chk(); k++;
    end
    if (k >= 300) chk("settle_timeout", 1, 0);
    repeat (extra) begin drive(); cycle_chk(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mm[i] = init_val(i);
    @(posedge clk); #1;
    do_reset(3);
    mem_clr = 0;
    settle(2);

    // pipeline load of the preloaded word
    pq.push_back('{1'b0, 32'h10, 32'h0});
    settle(1);
    chk("ld10", p_rdata, 32'hDEADBEEF);

    // store then load back
    pq.push_back('{1'b1, 32'h20, 32'h5});
    settle(1);
    chk("st_keeps_prdata", p_rdata, 32'hDEADBEEF);
    pq.push_back('{1'b0, 32'h20, 32'h0});
    settle(1);
    chk("ld20", p_rdata, 32'h5);

    // DMA write then read
    dq.push_back('{1'b1, 32'h40, 32'hCAFE0040});
    settle(1);
    dq.push_back('{1'b0, 32'h40, 32'h0});
    settle(1);
    chk("dma_rd40", d_rdata, 32'hCAFE0040);

    // both requesters held continuously: starvation guard interleaves DMA
    p_prob = 100; d_prob = 100; wd_prob = 0; order = 0; n_log = 0;
    rand_en = 1; log_en = 1; k = 0;
    while (n_log < 10 && k < 200) begin drive(); cycle_chk(); k++; end
    log_en = 0;
    if (k >= 200) chk("order_timeout", 1, 0);
    chk("grant_order", 32'(order[9:0]), 32'(10'b0000100001));
    settle(2);

    // pipeline request arrives while a DMA access is in flight
    dq.push_back('{1'b1, 32'h44, 32'h00001234});
    drive(); cycle_chk();
    pq.push_back('{1'b0, 32'h44, 32'h0});
    settle(1);
    chk("pl_after_dma", p_rdata, 32'h00001234);

    // reset in the final cycle of a store aborts it
    pq.push_back('{1'b1, 32'h30, 32'h77});
    drive(); cycle_chk();
    drive(); cycle_chk();
    chk("pre_abort_m_en", 32'(m_en), 1);
    #2 reset = 0;
    #1;
    chk("abort_m_en", 32'(m_en), 0);
    chk("abort_m_we", 32'(m_we), 0);
    chk("abort_m_addr", m_addr, 0);
    do_reset(2);
    settle(1);
    pq.push_back('{1'b0, 32'h30, 32'h0});
    settle(1);
    chk("no_partial_wr", p_rdata, init_val(48));

    // random mixed traffic with DMA withdrawals
    p_prob = 30; d_prob = 25; wd_prob = 10; rand_en = 1;
    repeat (3000) begin drive(); cycle_chk(); end
    settle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
